// File: rtl/rom_page_loader.sv
// ROM page loader: routes host download bytes into SDRAM expansion pages or system ROM slots.
// Optional macro ROM_LOADER_COMBO_EN enables the "Z0" combo-cartridge page remap.
module rom_page_loader #(
  parameter  int BANKS  = 2,
  parameter  int PAGE_W = 8,
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   i_ce_ref,
  input  logic                   i_ioctl_download,
  input  logic                   i_ioctl_wr,
  input  logic [24:0]            i_ioctl_addr,
  input  logic [7:0]             i_ioctl_dout,
  input  logic [7:0]             i_ioctl_index,
  input  logic [15:0]            i_ioctl_file_ext,
  output logic                   o_ioctl_wait,
  output logic                   o_mem_wr,
  output logic [22:0]            o_mem_addr,
  output logic [BANK_W-1:0]      o_mem_bank,
  output logic [7:0]             o_mem_dout,
  output logic [2**PAGE_W-1:0]   o_rom_map
);

  typedef enum logic [1:0] {IDLE, ARM, WRITE, NEXT} state_t;

  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BANKS - 1);

  state_t                r_state, w_state_nxt;
  logic                  r_wait, w_wait_nxt;
  logic                  r_wr, w_wr_nxt;
  logic [BANK_W-1:0]     r_bank, w_bank_nxt;
  logic [22:0]           r_addr;
  logic [7:0]            r_dout;
  logic                  r_is_exp;
  logic [8:0]            r_page;
  logic [2**PAGE_W-1:0]  r_rom_map;
  logic                  r_download_d;
`ifdef ROM_LOADER_COMBO_EN
  logic                  r_combo;
  logic                  w_combo_dec;
`endif

  logic [4:0]        w_hi, w_lo;
  logic [8:0]        w_page_dec;
  logic              w_dl_start;
  logic              w_is_exp;
  logic [10:0]       w_blk;
  logic [8:0]        w_sys_page;
  logic [7:0]        w_exp_page;
  logic              w_tgt_valid;
  logic [22:0]       w_tgt_addr;
  logic [BANK_W-1:0] w_tgt_bank;
  logic              w_load;
  logic              w_byte_done;

  // Returns {valid, nibble}; only '0'-'9' and uppercase 'A'-'F' are hex digits.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  assign w_dl_start = i_ioctl_download && !r_download_d && (i_ioctl_index != 8'd0);

  always_comb begin
    w_hi       = hex_nib(i_ioctl_file_ext[15:8]);
    w_lo       = hex_nib(i_ioctl_file_ext[7:0]);
    w_page_dec = 9'h1EE;
`ifdef ROM_LOADER_COMBO_EN
    w_combo_dec = 1'b0;
`endif
    if (i_ioctl_file_ext == 16'h5A5A) w_page_dec = 9'h000;
`ifdef ROM_LOADER_COMBO_EN
    else if (i_ioctl_file_ext == 16'h5A30) begin
      w_page_dec  = 9'h000;
      w_combo_dec = 1'b1;
    end
`endif
    else if (w_hi[4] && w_lo[4]) w_page_dec = {1'b0, w_hi[3:0], w_lo[3:0]};
  end

  always_comb begin
    w_is_exp   = (i_ioctl_index != 8'd0);
    w_blk      = i_ioctl_addr[24:14];
    w_exp_page = r_page[7:0] + i_ioctl_addr[21:14];
    w_tgt_bank = '0;
    case (w_blk[1:0])
      2'd0:    w_sys_page = 9'h000;
      2'd1:    w_sys_page = 9'h100;
      2'd2:    w_sys_page = 9'h107;
      default: w_sys_page = 9'h1FF;
    endcase
    if (w_is_exp) begin
      w_tgt_valid = 1'b1;
      w_tgt_addr  = {r_page[8], w_exp_page, i_ioctl_addr[13:0]};
    end else begin
      w_tgt_valid   = (w_blk < 11'd4) || ((w_blk < 11'd8) && (BANKS > 1));
      w_tgt_addr    = {w_sys_page, i_ioctl_addr[13:0]};
      w_tgt_bank[0] = w_blk[2];
    end
  end

  // NOTE: every combinational output is given a default before the case, so no latch can form.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_wr_nxt    = r_wr;
    w_bank_nxt  = r_bank;
    w_load      = 1'b0;
    w_byte_done = 1'b0;
    case (r_state)
      IDLE: if (i_ioctl_wr && w_tgt_valid) begin
        w_load      = 1'b1;
        w_wait_nxt  = 1'b1;
        w_bank_nxt  = w_tgt_bank;
        w_state_nxt = ARM;
      end
      ARM: if (i_ce_ref) begin
        w_wr_nxt    = 1'b1;
        w_state_nxt = WRITE;
      end
      WRITE: if (i_ce_ref) begin
        w_wr_nxt    = 1'b0;
        w_state_nxt = NEXT;
      end
      NEXT: begin
        if (r_is_exp && r_bank != LAST_BANK) begin
          w_bank_nxt  = r_bank + 1'b1;
          w_state_nxt = ARM;
        end else begin
          w_wait_nxt  = 1'b0;
          w_byte_done = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wait       <= 1'b0;
      r_wr         <= 1'b0;
      r_bank       <= '0;
      r_addr       <= '0;
      r_dout       <= '0;
      r_is_exp     <= 1'b0;
      r_page       <= 9'h1EE;
      r_rom_map    <= '0;
      // A download already running across reset must not re-decode the page.
      r_download_d <= 1'b1;
`ifdef ROM_LOADER_COMBO_EN
      r_combo      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_wait       <= w_wait_nxt;
      r_wr         <= w_wr_nxt;
      r_bank       <= w_bank_nxt;
      r_download_d <= i_ioctl_download;
      if (w_load) begin
        r_addr   <= w_tgt_addr;
        r_dout   <= i_ioctl_dout;
        r_is_exp <= w_is_exp;
      end
      if (w_byte_done && r_is_exp && r_addr[22])
        r_rom_map[r_addr[PAGE_W+13:14]] <= 1'b1;
      if (w_dl_start) begin
        r_page  <= w_page_dec;
`ifdef ROM_LOADER_COMBO_EN
        r_combo <= w_combo_dec;
      end else if (r_combo && w_byte_done && r_is_exp && r_addr[13:0] == 14'h3FFF) begin
        r_page  <= 9'h1FF;
        r_combo <= 1'b0;
`endif
      end
    end
  end

  assign o_ioctl_wait = r_wait;
  assign o_mem_wr     = r_wr;
  assign o_mem_addr   = r_addr;
  assign o_mem_bank   = r_bank;
  assign o_mem_dout   = r_dout;
  assign o_rom_map    = r_rom_map;

endmodule

// File: tb/tb_rom_page_loader.sv
// Bench for rom_page_loader: vector table of downloads with a write scoreboard, plus
// hand-written busy-write, download-drop, combo and mid-write reset sequences.
module tb_rom_page_loader;
  localparam int BANKS  = 2;
  localparam int PAGE_W = 8;
  localparam int BANK_W = 1;

  logic                 clk_sys = 1'b0;
  logic                 reset   = 1'b1;
  logic                 ce_ref  = 1'b0;
  logic                 dl      = 1'b0;
  logic                 wr      = 1'b0;
  logic [24:0]          addr    = '0;
  logic [7:0]           dout    = '0;
  logic [7:0]           index   = '0;
  logic [15:0]          ext     = '0;
  logic                 o_wait;
  logic                 mem_wr;
  logic [22:0]          mem_addr;
  logic [BANK_W-1:0]    mem_bank;
  logic [7:0]           mem_dout;
  logic [2**PAGE_W-1:0] rom_map;

  typedef struct {
    logic [7:0]  index;
    logic [15:0] ext;
    logic [24:0] addr;
    logic [7:0]  data;
    int          n_wr;
    logic [22:0] exp_addr;
    logic        exp_bank0;
    int          map_idx;
  } vec_t;

  typedef struct {
    logic [22:0]       addr;
    logic [BANK_W-1:0] bank;
    logic [7:0]        data;
  } wr_t;

  wr_t                  sb_q[$];
  vec_t                 vt[13];
  int                   checks = 0;
  int                   errors = 0;
  logic [2**PAGE_W-1:0] exp_map = '0;
  logic                 prev_wr = 1'b0;

  rom_page_loader #(.BANKS(BANKS), .PAGE_W(PAGE_W)) dut (
    .clk_sys          (clk_sys),
    .reset            (reset),
    .i_ce_ref         (ce_ref),
    .i_ioctl_download (dl),
    .i_ioctl_wr       (wr),
    .i_ioctl_addr     (addr),
    .i_ioctl_dout     (dout),
    .i_ioctl_index    (index),
    .i_ioctl_file_ext (ext),
    .o_ioctl_wait     (o_wait),
    .o_mem_wr         (mem_wr),
    .o_mem_addr       (mem_addr),
    .o_mem_bank       (mem_bank),
    .o_mem_dout       (mem_dout),
    .o_rom_map        (rom_map)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM reference strobe: one clock high in every four, changing just after the rising edge.
  initial begin
    forever begin
      repeat (3) @(posedge clk_sys);
      #1 ce_ref = 1'b1;
      @(posedge clk_sys);
      #1 ce_ref = 1'b0;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every rising mem_wr is matched against the oldest expected write.
  always @(negedge clk_sys) begin
    wr_t e;
    if (mem_wr && !prev_wr) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: write to 0x%0h bank %0d, expected no write", mem_addr, mem_bank);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_bank", mem_bank, e.bank);
        check("wr_data", mem_dout, e.data);
      end
    end
    prev_wr = mem_wr;
  end

  task automatic start_download(input logic [7:0] idx, input logic [15:0] e);
    @(negedge clk_sys);
    dl = 1'b0;
    repeat (2) @(negedge clk_sys);
    index = idx;
    ext   = e;
    dl    = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic push_expected(input int n_wr, input logic [22:0] ea, input logic eb0,
                               input logic [7:0] d);
    wr_t w;
    for (int b = 0; b < n_wr; b++) begin
      w.addr = ea;
      w.bank = BANK_W'(int'(eb0) + b);
      w.data = d;
      sb_q.push_back(w);
    end
  endtask

  task automatic pulse_wr(input string tag, input logic [24:0] a, input logic [7:0] d,
                          input int n_wr);
    @(negedge clk_sys);
    addr = a;
    dout = d;
    wr   = 1'b1;
    @(negedge clk_sys);
    wr = 1'b0;
    check({tag, "_wait_ack"}, o_wait, (n_wr != 0));
  endtask

  task automatic wait_idle(input string tag, input int n_wr);
    int ce_cnt;
    int cyc;
    ce_cnt = 0;
    cyc    = 0;
    while (o_wait && cyc < 400) begin
      if (ce_ref) ce_cnt++;
      @(negedge clk_sys);
      cyc++;
    end
    if (o_wait) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ioctl_wait high after %0d cycles, expected low", tag, cyc);
    end
    if (n_wr > 0) begin
      checks++;
      if (ce_cnt < 2 * n_wr - 1 || ce_cnt > 2 * n_wr + 1) begin
        errors++;
        $display("FAIL %s_latency: %0d ce_ref periods, expected %0d +/-1", tag, ce_cnt, 2 * n_wr);
      end
    end
    repeat (12) @(negedge clk_sys);
    check({tag, "_sb_drain"}, sb_q.size(), 0);
    check({tag, "_wait_low"}, o_wait, 1'b0);
  endtask

  task automatic send_byte(input string tag, input logic [24:0] a, input logic [7:0] d,
                           input int n_wr, input logic [22:0] ea, input logic eb0,
                           input int map_idx);
    push_expected(n_wr, ea, eb0, d);
    pulse_wr(tag, a, d, n_wr);
    wait_idle(tag, n_wr);
    if (map_idx >= 0) exp_map[map_idx] = 1'b1;
    check({tag, "_rom_map"}, rom_map, exp_map);
  endtask

  initial begin
    int cyc;

    //          index  ext(ASCII)  ioctl_addr     data   n  mem_addr       bank  map
    vt[0]  = '{8'h00, 16'h0000, 25'h0004000, 8'hA5, 1, 23'h400000, 1'b0, -1};   // sys blk1 -> 0x100
    vt[1]  = '{8'h00, 16'h0000, 25'h0020000, 8'h5A, 0, 23'h000000, 1'b0, -1};   // sys blk8 invalid
    vt[2]  = '{8'h00, 16'h0000, 25'h000C123, 8'h31, 1, 23'h7FC123, 1'b0, -1};   // sys blk3 -> 0x1FF
    vt[3]  = '{8'h00, 16'h0000, 25'h0018010, 8'h46, 1, 23'h41C010, 1'b1, -1};   // sys blk6 -> 0x107 bank1
    vt[4]  = '{8'h00, 16'h0000, 25'h0000007, 8'h07, 1, 23'h000007, 1'b0, -1};   // sys blk0 -> 0x000
    vt[5]  = '{8'h01, 16'h3037, 25'h0000005, 8'h3C, 2, 23'h01C005, 1'b0, -1};   // "07"
    vt[6]  = '{8'h01, 16'h5158, 25'h0000123, 8'h99, 2, 23'h7B8123, 1'b0, 8'hEE}; // "QX" malformed
    vt[7]  = '{8'h01, 16'h5A5A, 25'h0008001, 8'h12, 2, 23'h008001, 1'b0, -1};   // "ZZ" -> page 0
    vt[8]  = '{8'h01, 16'h6130, 25'h004C000, 8'hE1, 2, 23'h404000, 1'b0, 8'h01}; // "a0" lowercase
    vt[9]  = '{8'h01, 16'h4646, 25'h0004002, 8'hF0, 2, 23'h000002, 1'b0, -1};   // "FF" page wraps
    vt[10] = '{8'h01, 16'h3941, 25'h0000200, 8'h9A, 2, 23'h268200, 1'b0, -1};   // "9A"
    vt[11] = '{8'h01, 16'h355A, 25'h0003FFF, 8'h5F, 2, 23'h7BBFFF, 1'b0, 8'hEE}; // "5Z" mixed
    vt[12] = '{8'h05, 16'h3343, 25'h1004000, 8'h3C, 2, 23'h0F4000, 1'b0, -1};   // "3C", high addr bits

    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_wait", o_wait, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_addr", mem_addr, 23'h0);
    check("rst_mem_bank", mem_bank, 1'b0);
    check("rst_mem_dout", mem_dout, 8'h0);
    check("rst_rom_map", rom_map, '0);

    foreach (vt[i]) begin
      start_download(vt[i].index, vt[i].ext);
      send_byte($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].n_wr,
                vt[i].exp_addr, vt[i].exp_bank0, vt[i].map_idx);
    end

    // Second strobe while busy is dropped; download falling mid-byte does not abort it.
    start_download(8'h01, 16'h3037);
    push_expected(2, 23'h01C010, 1'b0, 8'h11);
    pulse_wr("busy", 25'h0000010, 8'h11, 2);
    @(negedge clk_sys);
    addr = 25'h0000020;
    dout = 8'h22;
    wr   = 1'b1;
    dl   = 1'b0;
    @(negedge clk_sys);
    wr = 1'b0;
    wait_idle("busy", 2);
    check("busy_rom_map", rom_map, exp_map);

`ifdef ROM_LOADER_COMBO_EN
    start_download(8'h01, 16'h5A30);
    send_byte("combo_0000", 25'h0000000, 8'hC0, 2, 23'h000000, 1'b0, -1);
    send_byte("combo_3fff", 25'h0003FFF, 8'hC1, 2, 23'h003FFF, 1'b0, -1);
    send_byte("combo_4000", 25'h0004000, 8'hC2, 2, 23'h400000, 1'b0, 8'h00);
    send_byte("combo_4001", 25'h0004001, 8'hC3, 2, 23'h400001, 1'b0, 8'h00);
`else
    start_download(8'h01, 16'h5A30);
    send_byte("z0_0000", 25'h0000000, 8'hC0, 2, 23'h7B8000, 1'b0, 8'hEE);
    send_byte("z0_4000", 25'h0004000, 8'hC1, 2, 23'h7BC000, 1'b0, 8'hEF);
`endif

    // Reset during the bank-0 write, then a normal byte with the page back at 0x1EE.
    start_download(8'h01, 16'h3037);
    push_expected(2, 23'h01C001, 1'b0, 8'h77);
    pulse_wr("rst_mid", 25'h0000001, 8'h77, 2);
    cyc = 0;
    while (!mem_wr && cyc < 100) begin
      @(negedge clk_sys);
      cyc++;
    end
    check("rst_mid_wr_seen", mem_wr, 1'b1);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check("rst_mid_mem_wr", mem_wr, 1'b0);
    check("rst_mid_wait", o_wait, 1'b0);
    check("rst_mid_rom_map", rom_map, '0);
    check("rst_mid_mem_addr", mem_addr, 23'h0);
    sb_q.delete();
    exp_map = '0;
    send_byte("post_rst", 25'h0000001, 8'h78, 2, 23'h7B8001, 1'b0, 8'hEE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
